// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: shares one combinational single-precision adder among NREQ
// requesters using round-robin arbitration, with one operation in flight at a time.
// Optional feature macro: FPADD_ZERO_BYPASS_EN. When it is defined, an operand with
// zero magnitude returns the other operand directly and skips the EXEC cycle.
module fp_add_scheduler #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          fa_a,
    output logic [31:0]          fa_b,
    input  logic [31:0]          fa_sum,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    input  logic                 rsp_ready,
    output logic                 busy
);

    localparam int unsigned NREQ_U = NREQ;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic            grant_any;
    logic            accept;
    logic            bypass;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [31:0]     bypass_sum;

    // Round-robin search starting just after the most recent grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            cand = IDW'((32'(last_grant) + k) % NREQ_U);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Grant vector is only offered in IDLE and outside reset.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (rst_n && state == IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
            accept               = 1'b1;
        end
    end

    // Operand selection and the optional zero-magnitude shortcut.
    always_comb begin
        sel_a      = req_a[32*int'(grant_idx) +: 32];
        sel_b      = req_b[32*int'(grant_idx) +: 32];
`ifdef FPADD_ZERO_BYPASS_EN
        bypass     = (sel_a[30:0] == '0) || (sel_b[30:0] == '0);
        bypass_sum = (sel_a[30:0] == '0) ? sel_b : sel_a;
`else
        bypass     = 1'b0;
        bypass_sum = '0;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = bypass ? RESP : EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, ID and result registers; held stable outside their load points.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fa_a       <= '0;
            fa_b       <= '0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            if (accept) begin
                fa_a       <= sel_a;
                fa_b       <= sel_b;
                rsp_id     <= grant_idx;
                last_grant <= grant_idx;
                if (bypass) begin
                    rsp_sum <= bypass_sum;
                end
            end
            if (state == EXEC) begin
                rsp_sum <= fa_sum;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
